output_port_rr: RTL and testbench
=================================

Name: output_port_rr

Overview:
- Parametrised, clocked successor to the 4-input combinational output port.
- Arbitrates NUM_IN router input channels for one output link using round-robin priority and wormhole locking: a granted packet holds the port from its header flit through its tail flit.
- Flits pass through an output FIFO to the link using a valid/ready handshake.
- Sits at each router output; one instance per output direction.

Parameters:
- NUM_IN, 4, number of competing input channels (>=2).
- FLIT_W, 12, payload flit width delivered to the link.
- HDR_W, 2, per-flit routing tag width prepended above the payload.
- PORT_ADDR, 1, routing tag value that selects this output port.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*(HDR_W+FLIT_W)  packed channels; channel i at [i*(HDR_W+FLIT_W) +: HDR_W+FLIT_W]; tag in the top HDR_W bits.
- in_valid  in  NUM_IN  channel i presents a flit.
- in_last  in  NUM_IN  flit on channel i is the packet tail (a header flit with last=1 is a single-flit packet).
- in_ready  out  NUM_IN  flit on channel i accepted this cycle (inverse of legacy portBlock).
- out_data  out  FLIT_W  FIFO head payload, tag stripped.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  link consumes head when out_valid=1.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- busy  out  1  port locked to a packet (state LOCKED).

Behaviour:
- Request: req[i] = in_valid[i] & (tag_i == PORT_ADDR). Only header flits are tag-checked; body/tail flits of the locked channel are accepted regardless of tag.
- States: IDLE, LOCKED. Registers: state, owner (index), rr_ptr (index), FIFO storage and pointers.
- IDLE:
  - The winner is the first requesting channel at or after rr_ptr, wrapping modulo NUM_IN; computed combinationally.
  - If any req and FIFO not full: in_ready[winner]=1 and the flit is written.
  - rr_ptr <= (winner+1) mod NUM_IN.
  - If in_last[winner]=0, go to LOCKED with owner <= winner; otherwise stay IDLE.
  - If the FIFO is full: no grant, rr_ptr unchanged.
- LOCKED:
  - in_ready[owner] = in_valid[owner] & ~full; all other in_ready bits are 0.
  - Accepting a flit with in_last=1 returns the block to IDLE.
  - Other requesters wait even when the owner is idle (wormhole).
- At most one in_ready bit is high per cycle. in_ready is combinational from inputs and state; no cycle bubble is inserted.
- FIFO:
  - Write on accept; read when out_valid & out_ready.
  - Simultaneous read and write is allowed when full (the read frees the slot in the same cycle, so full is evaluated as "full and not reading") and when empty (the written data is not visible until the next cycle).
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count is +1, -1, or unchanged on simultaneous read and write.
- Latency: a flit accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 if the FIFO was empty.
- Ordering: flits leave in acceptance order; packets never interleave on the output.
- Reset (any cycle, including mid-packet):
  - state=IDLE, owner=0, rr_ptr=0, FIFO emptied.
  - Outputs: out_valid=0, fifo_count=0, busy=0, in_ready=0 during the reset cycle, out_data=0.
  - A partially forwarded packet is dropped; upstream resynchronisation is the sender's responsibility.
- A header arriving with in_last=1 while in IDLE occupies one cycle and never sets busy.

Test Plan:
- Single input, single-flit packet: ch1 tag=1, last=1, payload 0xABC, out_ready=1 -> in_ready[1]=1 in cycle 0; out_valid=1 with out_data=0xABC in cycle 1; busy stays 0.
- Round-robin fairness: ch0 and ch2 continuously send 1-flit packets with tag=1 from reset -> grants go 0,2,0,2..., rr_ptr alternates 1,3,1,3.
- Wormhole lock: ch3 sends a 3-flit packet while ch1 is requesting throughout -> ch3 receives three consecutive grants with busy=1; ch1 is granted only in the cycle after ch3's tail.
- Backpressure: out_ready=0, ch0 streams a 6-flit packet, FIFO_DEPTH=4 -> 4 flits accepted, fifo_count=4, in_ready[0]=0; raise out_ready -> concurrent read and write keep fifo_count at 4 with no flit lost or duplicated.
- Tag filtering: ch2 header tag=3 with out_valid low -> no grant, FIFO unchanged; change tag to 1 -> granted in the same cycle.
- Mid-packet reset: assert reset after 2 of 4 flits of ch1 -> next cycle busy=0, fifo_count=0, out_valid=0; a new ch0 header is then granted at rr_ptr=0.

Source files
------------

// File: rtl/output_port_rr.sv
// Round-robin wormhole arbiter for one router output link.
// NUM_IN tagged input channels share an output FIFO that feeds the link with valid/ready.
module output_port_rr #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned FLIT_W     = 12,
  parameter int unsigned HDR_W      = 2,
  parameter int unsigned PORT_ADDR  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_IN*(HDR_W+FLIT_W)-1:0]     in_data,
  input  logic [NUM_IN-1:0]                    in_valid,
  input  logic [NUM_IN-1:0]                    in_last,
  output logic [NUM_IN-1:0]                    in_ready,
  output logic [FLIT_W-1:0]                    out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
  output logic                                 busy
);

  localparam int unsigned CH_W  = HDR_W + FLIT_W;
  localparam int unsigned IDX_W = $clog2(NUM_IN);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    winner, sel;
  logic [NUM_IN-1:0]   req;
  logic                any_req;

  logic [FLIT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_en, rd_en, full;
  logic [FLIT_W-1:0]   wr_data;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      req[i] = in_valid[i] && (in_data[i*CH_W+FLIT_W +: HDR_W] == HDR_W'(PORT_ADDR));
    end
  end

  // First requester at or after rr_q, wrapping modulo NUM_IN.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      int unsigned idx;
      idx = (32'(rr_q) + k) % NUM_IN;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = IDX_W'(idx);
      end
    end
  end

  assign out_valid  = (cnt_q != '0);
  assign rd_en      = out_valid && out_ready;
  // A same-cycle read frees the slot, so a full FIFO can still accept.
  assign full       = (cnt_q == CNT_W'(FIFO_DEPTH)) && !rd_en;
  assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
  assign fifo_count = cnt_q;
  assign busy       = (state_q == LOCKED);
  assign wr_data    = in_data[sel*CH_W +: FLIT_W];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    in_ready = '0;
    wr_en    = 1'b0;
    sel      = owner_q;
    case (state_q)
      IDLE: begin
        sel = winner;
        if (any_req && !full) begin
          wr_en            = 1'b1;
          in_ready[winner] = 1'b1;
          rr_d = (winner == IDX_W'(NUM_IN-1)) ? '0 : winner + 1'b1;
          if (!in_last[winner]) begin
            state_d = LOCKED;
            owner_d = winner;
          end
        end
      end
      LOCKED: begin
        if (in_valid[owner_q] && !full) begin
          wr_en             = 1'b1;
          in_ready[owner_q] = 1'b1;
          if (in_last[owner_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      in_ready = '0;
      wr_en    = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_output_port_rr.sv
// Directed bench for output_port_rr; expected payloads are queued on hand-computed grants
// and a negedge monitor pops and compares them against every link transfer.
module tb_output_port_rr;
  localparam int NI = 4;
  localparam int FW = 12;
  localparam int CW = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic [NI*CW-1:0]  in_data;
  logic [NI-1:0]     in_valid, in_last, in_ready;
  logic [FW-1:0]     out_data;
  logic              out_valid, out_ready;
  logic [2:0]        fifo_count;
  logic              busy;

  always #5 clk = ~clk;

  output_port_rr #(
    .NUM_IN(4), .FLIT_W(12), .HDR_W(2), .PORT_ADDR(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] pay [NI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [1:0] tag,
                        input logic [FW-1:0] p, input logic l);
    in_valid[ch] = v;
    in_last[ch]  = l;
    pay[ch]      = p;
    in_data[ch*CW +: CW] = {tag, p};
  endtask

  task automatic clear_all();
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
  endtask

  // Check grants at the negedge and queue the payload of each expected grant.
  task automatic step(input logic [NI-1:0] er, input logic eb, input string name);
    @(negedge clk);
    check({name, " in_ready"}, 32'(in_ready), 32'(er));
    check({name, " busy"}, 32'(busy), 32'(eb));
    for (int i = 0; i < NI; i++) if (er[i]) exp_q.push_back(pay[i]);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'h0);
    exp_q.delete();
    adv();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: got %0h required no output", out_data);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) pay[i] = '0;
    reset     = 1'b1;
    out_ready = 1'b1;
    clear_all();
    set_ch(0, 1'b1, 2'd1, 12'h111, 1'b1);
    adv();
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'h0);
    adv();
    reset = 1'b0;
    clear_all();
    @(negedge clk);
    check("reset busy", 32'(busy), 32'h0);
    check("reset fifo_count", 32'(fifo_count), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data", 32'(out_data), 32'h0);
    adv();

    // Single-flit packet, one-cycle latency to the link.
    set_ch(1, 1'b1, 2'd1, 12'hABC, 1'b1);
    step(4'b0010, 1'b0, "t1_grant");
    adv();
    clear_all();
    step(4'b0000, 1'b0, "t1_after");
    check("t1 out_valid", 32'(out_valid), 32'h1);
    check("t1 fifo_count", 32'(fifo_count), 32'h1);
    adv();
    step(4'b0000, 1'b0, "t1_idle");
    check("t1 drained", 32'(fifo_count), 32'h0);
    adv();

    // Round robin between ch0 and ch2.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_ch(0, 1'b1, 2'd1, 12'h100 + 12'(k), 1'b1);
      set_ch(2, 1'b1, 2'd1, 12'h200 + 12'(k), 1'b1);
      step((k % 2 == 0) ? 4'b0001 : 4'b0100, 1'b0, "t2_rr");
      adv();
    end
    clear_all();

    // Wormhole: rr now at 3, ch3 three-flit packet blocks ch1.
    set_ch(3, 1'b1, 2'd1, 12'h300, 1'b0);
    set_ch(1, 1'b1, 2'd1, 12'h150, 1'b1);
    step(4'b1000, 1'b0, "t3_hdr");
    adv();
    set_ch(3, 1'b1, 2'd0, 12'h301, 1'b0);
    step(4'b1000, 1'b1, "t3_body");
    adv();
    set_ch(3, 1'b1, 2'd2, 12'h302, 1'b1);
    step(4'b1000, 1'b1, "t3_tail");
    adv();
    set_ch(3, 1'b0, 2'd0, 12'h000, 1'b0);
    step(4'b0010, 1'b0, "t3_ch1");
    adv();
    clear_all();

    // Backpressure: fill the FIFO, then concurrent read and write at full.
    do_reset();
    out_ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      set_ch(0, 1'b1, (f == 0) ? 2'd1 : 2'd0, 12'h400 + 12'(f), 1'b0);
      step(4'b0001, (f != 0), "t4_fill");
      adv();
    end
    set_ch(0, 1'b1, 2'd0, 12'h404, 1'b0);
    step(4'b0000, 1'b1, "t4_stall");
    check("t4 full count", 32'(fifo_count), 32'h4);
    check("t4 out_valid", 32'(out_valid), 32'h1);
    adv();
    step(4'b0000, 1'b1, "t4_stall2");
    adv();
    out_ready = 1'b1;
    step(4'b0001, 1'b1, "t4_rw");
    check("t4 rw count", 32'(fifo_count), 32'h4);
    adv();
    set_ch(0, 1'b1, 2'd0, 12'h405, 1'b1);
    step(4'b0001, 1'b1, "t4_tail");
    check("t4 tail count", 32'(fifo_count), 32'h4);
    adv();
    clear_all();
    step(4'b0000, 1'b0, "t4_done");
    check("t4 done count", 32'(fifo_count), 32'h4);
    repeat (6) adv();

    // Tag filtering.
    set_ch(2, 1'b1, 2'd3, 12'h5A5, 1'b1);
    step(4'b0000, 1'b0, "t5_badtag");
    check("t5 out_valid", 32'(out_valid), 32'h0);
    check("t5 fifo_count", 32'(fifo_count), 32'h0);
    adv();
    set_ch(2, 1'b1, 2'd1, 12'h5A5, 1'b1);
    step(4'b0100, 1'b0, "t5_goodtag");
    adv();
    clear_all();
    step(4'b0000, 1'b0, "t5_after");
    check("t5 out_valid after", 32'(out_valid), 32'h1);
    adv();

    // Mid-packet reset: lock and rr pointer must both clear.
    set_ch(1, 1'b1, 2'd1, 12'h610, 1'b0);
    step(4'b0010, 1'b0, "t6_hdr");
    adv();
    set_ch(1, 1'b1, 2'd0, 12'h611, 1'b0);
    step(4'b0010, 1'b1, "t6_body");
    adv();
    reset = 1'b1;
    set_ch(1, 1'b1, 2'd0, 12'h612, 1'b0);
    step(4'b0000, 1'b1, "t6_rst");
    exp_q.delete();
    adv();
    reset = 1'b0;
    set_ch(0, 1'b1, 2'd1, 12'h700, 1'b1);
    set_ch(1, 1'b1, 2'd1, 12'h6FF, 1'b1);
    set_ch(3, 1'b1, 2'd1, 12'h3FF, 1'b1);
    step(4'b0001, 1'b0, "t6_new");
    check("t6 fifo_count", 32'(fifo_count), 32'h0);
    check("t6 out_valid", 32'(out_valid), 32'h0);
    adv();
    clear_all();
    step(4'b0000, 1'b0, "t6_out");
    check("t6 out_valid after", 32'(out_valid), 32'h1);
    adv();

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) adv();
    check("drain pending", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
